id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that feeds the ALU. Accepts decoded instructions from the decode stage over a valid/ready handshake and buffers them in a two-entry skid buffer, so `in_ready` is a registered signal. It selects operand B (register or immediate), resolves RAW hazards by forwarding from the MEM and WB stages, and splits the 5-bit opcode into the ALU's `op_code_1` and `op_code_2` fields.

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute stage: two-entry skid buffer, operand B select, MEM/WB forwarding
// Optional feature macro: ID_EX_FWD_EN (forwarding compiled in when defined).
module id_ex_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op_code,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic        fwd_mem_valid,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    input  logic        fwd_wb_valid,
    input  logic [4:0]  fwd_wb_rd,
    input  logic [31:0] fwd_wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [3:0]  alu_op_code_1,
    output logic        alu_op_code_2,
    output logic [4:0]  out_rd_addr
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    state_t state, state_n;
    entry_t main_r, skid_r, main_n, skid_n;
    entry_t in_e, main_f, skid_f, in_f;
    logic   in_ready_r;
    logic   accept, fire;
    logic [31:0] opa, opb;

    assign in_e = '{op: in_op_code, rd: in_rd_addr, rs1: in_rs1_addr, rs2: in_rs2_addr,
                    use_imm: in_use_imm, a: in_rs1_data,
                    b: in_use_imm ? in_imm : in_rs2_data};

`ifdef ID_EX_FWD_EN
    // WB results are folded into stored operands so a stalled op keeps them after WB retires.
    function automatic entry_t wb_refresh(input entry_t e, input logic v,
                                          input logic [4:0] rd, input logic [31:0] d);
        entry_t r;
        r = e;
        if (v && (rd != 5'd0) && (rd == e.rs1))
            r.a = d;
        if (v && (rd != 5'd0) && !e.use_imm && (rd == e.rs2))
            r.b = d;
        return r;
    endfunction

    assign main_f = wb_refresh(main_r, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    assign skid_f = wb_refresh(skid_r, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    assign in_f   = wb_refresh(in_e,   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

    assign opa = (fwd_mem_valid && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == main_r.rs1))
               ? fwd_mem_data : main_r.a;
    assign opb = (fwd_mem_valid && (fwd_mem_rd != 5'd0) && !main_r.use_imm
                  && (fwd_mem_rd == main_r.rs2)) ? fwd_mem_data : main_r.b;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data};

    assign main_f = main_r;
    assign skid_f = skid_r;
    assign in_f   = in_e;
    assign opa    = main_r.a;
    assign opb    = main_r.b;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready_r;
    assign fire      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= EMPTY;
            main_r     <= '0;
            skid_r     <= '0;
            in_ready_r <= 1'b1;
        end else begin
            state      <= state_n;
            main_r     <= main_n;
            skid_r     <= skid_n;
            in_ready_r <= (state_n != FULL);
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_f;
        skid_n  = skid_f;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_n = ONE;
                    main_n  = in_f;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    main_n = in_f;
                end else if (accept) begin
                    state_n = FULL;
                    skid_n  = in_f;
                end else if (fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_n = ONE;
                    main_n  = skid_f;
                end
            end
            default: state_n = EMPTY;
        endcase
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end
    end

    // With no valid op the ALU sees ADD 0+0.
    assign alu_operand_a = out_valid ? opa : 32'd0;
    assign alu_operand_b = out_valid ? opb : 32'd0;
    assign alu_op_code_1 = out_valid ? main_r.op[3:0] : 4'd0;
    assign alu_op_code_2 = out_valid ? main_r.op[4] : 1'b0;
    assign out_rd_addr   = out_valid ? main_r.rd : 5'd0;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage: vector table, corner sequences, random vs queue model
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready, in_use_imm, out_valid, out_ready;
    logic [4:0]  in_op_code, in_rs1_addr, in_rs2_addr, in_rd_addr, out_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        fwd_mem_valid, fwd_wb_valid, alu_op_code_2;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data, alu_operand_a, alu_operand_b;
    logic [3:0]  alu_op_code_1;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op_code(in_op_code), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_op_code_1(alu_op_code_1), .alu_op_code_2(alu_op_code_2), .out_rd_addr(out_rd_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  op, rd, rs1, rs2;
        logic [31:0] r1d, r2d, imm;
        logic        ui, ordy, fl, mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        e_ov, e_ir;
        logic [31:0] e_a, e_b;
        logic [3:0]  e_op1;
        logic        e_op2;
        logic [4:0]  e_rd;
    } vec_t;

    typedef struct {
        logic [4:0]  op, rd, rs1, rs2;
        logic        ui;
        logic [31:0] a, b;
    } ins_t;

    ins_t mq[$];
    bit   m_ir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic ir,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op1, input logic op2, input logic [4:0] rd);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        check({tag, ".operand_a"}, alu_operand_a, a);
        check({tag, ".operand_b"}, alu_operand_b, b);
        check({tag, ".op_code_1"}, {28'd0, alu_op_code_1}, {28'd0, op1});
        check({tag, ".op_code_2"}, {31'd0, alu_op_code_2}, {31'd0, op2});
        check({tag, ".rd"}, {27'd0, out_rd_addr}, {27'd0, rd});
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_op_code = 0; in_rs1_addr = 0; in_rs2_addr = 0;
        in_rd_addr = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
        out_ready = 0; fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        mq.delete();
        m_ir = 1;
    endtask

    task automatic push_in(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] r1d, input logic [31:0] r2d);
        in_valid = 1; in_op_code = op; in_rd_addr = rd; in_rs1_addr = rs1; in_rs2_addr = rs2;
        in_rs1_data = r1d; in_rs2_data = r2d; in_use_imm = 0; in_imm = 0;
    endtask

    function automatic ins_t wb_apply(input ins_t e);
        ins_t r = e;
        if (FWD && fwd_wb_valid && fwd_wb_rd != 0 && fwd_wb_rd == e.rs1) r.a = fwd_wb_data;
        if (FWD && fwd_wb_valid && fwd_wb_rd != 0 && !e.ui && fwd_wb_rd == e.rs2) r.b = fwd_wb_data;
        return r;
    endfunction

    // Reference: an instruction queue of depth two; ready means room for another instruction.
    task automatic model_edge();
        ins_t n;
        bit acc, fire;
        if (flush) begin
            mq.delete();
        end else begin
            acc  = in_valid && m_ir;
            fire = (mq.size() > 0) && out_ready;
            n = '{op: in_op_code, rd: in_rd_addr, rs1: in_rs1_addr, rs2: in_rs2_addr,
                  ui: in_use_imm, a: in_rs1_data, b: in_use_imm ? in_imm : in_rs2_data};
            n = wb_apply(n);
            foreach (mq[i]) mq[i] = wb_apply(mq[i]);
            if (fire) void'(mq.pop_front());
            if (acc) mq.push_back(n);
        end
        m_ir = (mq.size() < 2);
    endtask

    task automatic model_check(input string tag);
        ins_t h;
        logic [31:0] ea, eb;
        if (mq.size() == 0) begin
            check_outs(tag, 0, m_ir, 0, 0, 0, 0, 0);
        end else begin
            h  = mq[0];
            ea = (FWD && fwd_mem_valid && fwd_mem_rd != 0 && fwd_mem_rd == h.rs1) ? fwd_mem_data : h.a;
            eb = (FWD && fwd_mem_valid && fwd_mem_rd != 0 && !h.ui && fwd_mem_rd == h.rs2) ? fwd_mem_data : h.b;
            check_outs(tag, 1, m_ir, ea, eb, h.op[3:0], h.op[4], h.rd);
        end
    endtask

    vec_t vec[16];

    initial begin
        vec[0]  = '{1,'h10,1,1,2,7,3,0,0,1,0,0,0,0,                 0,1,0,0,0,0,0};
        vec[1]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,                    1,1,7,3,0,1,1};
        vec[2]  = '{1,3,2,1,2,11,22,0,0,0,0,0,0,0,                  0,1,0,0,0,0,0};
        vec[3]  = '{1,4,3,1,2,33,44,0,0,0,0,0,0,0,                  1,1,11,22,3,0,2};
        vec[4]  = '{1,5,4,1,2,55,66,0,0,0,0,0,0,0,                  1,0,11,22,3,0,2};
        vec[5]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,                    1,0,11,22,3,0,2};
        vec[6]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,                    1,1,33,44,4,0,3};
        vec[7]  = '{1,1,5,6,5,'h100,9,'hFFFFFFFC,1,1,0,1,5,'hDEAD,   0,1,0,0,0,0,0};
        vec[8]  = '{0,0,0,0,0,0,0,0,0,1,0,1,5,'hDEAD,                1,1,'h100,'hFFFFFFFC,1,0,5};
        vec[9]  = '{1,2,6,1,2,1,2,0,0,0,0,0,0,0,                    0,1,0,0,0,0,0};
        vec[10] = '{1,6,7,1,2,3,4,0,0,0,0,0,0,0,                    1,1,1,2,2,0,6};
        vec[11] = '{1,7,8,1,2,5,6,0,0,0,1,0,0,0,                    1,0,1,2,2,0,6};
        vec[12] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,                    0,1,0,0,0,0,0};
        vec[13] = '{1,8,9,1,2,'h77,'h88,0,0,1,0,0,0,0,              0,1,0,0,0,0,0};
        vec[14] = '{1,9,10,1,2,1,1,0,0,1,1,0,0,0,                   1,1,'h77,'h88,8,0,9};
        vec[15] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,                    0,1,0,0,0,0,0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = vec[i].iv; in_op_code = vec[i].op; in_rd_addr = vec[i].rd;
            in_rs1_addr = vec[i].rs1; in_rs2_addr = vec[i].rs2; in_rs1_data = vec[i].r1d;
            in_rs2_data = vec[i].r2d; in_imm = vec[i].imm; in_use_imm = vec[i].ui;
            out_ready = vec[i].ordy; flush = vec[i].fl; fwd_mem_valid = vec[i].mv;
            fwd_mem_rd = vec[i].mrd; fwd_mem_data = vec[i].md;
            #1;
            check_outs($sformatf("vec%0d", i), vec[i].e_ov, vec[i].e_ir, vec[i].e_a, vec[i].e_b,
                       vec[i].e_op1, vec[i].e_op2, vec[i].e_rd);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset between edges while both entries are occupied.
        do_reset();
        push_in(5'h0A, 5'd3, 5'd1, 5'd2, 32'h1111, 32'h2222);
        @(posedge clk); @(negedge clk);
        push_in(5'h0B, 5'd4, 5'd1, 5'd2, 32'h3333, 32'h4444);
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        #1 check_outs("pre_rst", 1, 0, 32'h1111, 32'h2222, 4'hA, 0, 5'd3);
        #1 rstn = 0;
        #1 check_outs("async_rst", 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1;
        #1 check_outs("post_rst", 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);

`ifdef ID_EX_FWD_EN
        // MEM beats WB, WB persists into the stored operand, x0 is never forwarded.
        do_reset();
        push_in(5'h02, 5'd7, 5'd3, 5'd4, 32'h11, 32'h22);
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        fwd_mem_valid = 1; fwd_mem_rd = 3; fwd_mem_data = 32'hAA;
        fwd_wb_valid = 1; fwd_wb_rd = 3; fwd_wb_data = 32'hBB;
        #1 check("fwd_mem_over_wb", alu_operand_a, 32'hAA);
        @(posedge clk); @(negedge clk);
        fwd_mem_valid = 0;
        fwd_wb_rd = 4; fwd_wb_data = 32'hCC;
        #1 check("wb_refresh_a", alu_operand_a, 32'hBB);
        check("wb_not_comb_b", alu_operand_b, 32'h22);
        @(posedge clk); @(negedge clk);
        fwd_wb_valid = 0;
        #1 check("wb_held_b", alu_operand_b, 32'hCC);
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
        push_in(5'h01, 5'd8, 5'd0, 5'd5, 32'h55, 32'h66);
        fwd_wb_valid = 1; fwd_wb_rd = 0; fwd_wb_data = 32'h77;
        @(posedge clk); @(negedge clk);
        in_valid = 0; fwd_wb_valid = 0;
        fwd_mem_valid = 1; fwd_mem_rd = 0; fwd_mem_data = 32'h99;
        #1 check("x0_no_fwd", alu_operand_a, 32'h55);
        @(negedge clk);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom % 4) != 0;
            in_op_code = 5'($urandom); in_rd_addr = 5'($urandom);
            in_rs1_addr = 5'($urandom % 4); in_rs2_addr = 5'($urandom % 4);
            in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
            in_use_imm = 1'($urandom % 2);
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 16) == 0;
            fwd_mem_valid = 1'($urandom % 2); fwd_mem_rd = 5'($urandom % 4); fwd_mem_data = $urandom;
            fwd_wb_valid = 1'($urandom % 2); fwd_wb_rd = 5'($urandom % 4); fwd_wb_data = $urandom;
            #1 model_check($sformatf("rnd%0d", c));
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
